linebuffer_ring: RTL

LINEBUFFER_RING -- requirements
Module: linebuffer_ring

---
 rtl/linebuffer_pkg.sv | 13 +
 rtl/linebuffer_bank.sv | 49 ++++
 rtl/linebuffer_ring.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/linebuffer_pkg.sv
// Shared constants and clear-engine state encoding for the rotating line buffer.
package linebuffer_pkg;

  localparam int TILE_PIX  = 16;
  localparam int TILE_LW   = $clog2(TILE_PIX);
  localparam int PIX_W_DEF = 16;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/linebuffer_bank.sv
// One line bank: port A writes a masked 16-pixel tile, port B reads/writes one pixel.
module linebuffer_bank
  import linebuffer_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int PIXELS = 640,
  parameter int TILES  = PIXELS / TILE_PIX,
  parameter int PAW    = $clog2(PIXELS),
  parameter int TAW    = $clog2(TILES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TAW-1:0]            a_addr_i,
  input  logic [PIX_W*TILE_PIX-1:0] a_data_i,
  input  logic [TILE_PIX-1:0]       a_mask_i,
  input  logic                      a_we_i,
  input  logic [PAW-1:0]            b_addr_i,
  input  logic [PIX_W-1:0]          b_data_i,
  input  logic                      b_we_i,
  output logic [PIX_W-1:0]          b_q_o
);

  logic [PIX_W-1:0] mem [PIXELS];
  logic             a_ok;
  logic             b_ok;

  assign a_ok = {1'b0, a_addr_i} < (TAW+1)'(TILES);
  assign b_ok = {1'b0, b_addr_i} < (PAW+1)'(PIXELS);

  // NOTE: the storage array is deliberately left out of reset so it maps onto
  // block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (a_we_i && a_ok) begin
      for (int i = 0; i < TILE_PIX; i++) begin
        if (a_mask_i[i]) mem[{a_addr_i, i[TILE_LW-1:0]}] <= a_data_i[i*PIX_W +: PIX_W];
      end
    end
    // Issued after the tile loop so the pixel port wins on a shared pixel.
    if (b_we_i && b_ok) mem[b_addr_i] <= b_data_i;
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) b_q_o <= '0;
    else       b_q_o <= b_ok ? mem[b_addr_i] : '0;
  end

endmodule

// File: rtl/linebuffer_ring.sv
// Ring of NUM_BUF line banks rotating display/draw roles, with a tile-rate clear engine.
module linebuffer_ring
  import linebuffer_pkg::*;
#(
  parameter int NUM_BUF = 2,
  parameter int PIXELS  = 640,
  parameter int PIX_W   = PIX_W_DEF,
  localparam int TILES  = PIXELS / TILE_PIX,
  localparam int TILE_W = PIX_W * TILE_PIX,
  localparam int PAW    = $clog2(PIXELS),
  localparam int TAW    = $clog2(TILES),
  localparam int SW     = $clog2(NUM_BUF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              swap,
  input  logic [PIX_W-1:0]  clear_color,
  input  logic [PAW-1:0]    disp_addr,
  output logic [PIX_W-1:0]  disp_q,
  input  logic [TAW-1:0]    draw_tile_addr,
  input  logic [TILE_W-1:0] draw_tile_data,
  input  logic [TILE_PIX-1:0] draw_tile_mask,
  input  logic              draw_tile_we,
  input  logic [PAW-1:0]    draw_pix_addr,
  input  logic [PIX_W-1:0]  draw_pix_data,
  input  logic              draw_pix_we,
  output logic [PIX_W-1:0]  draw_pix_q,
  output logic              draw_ready,
  output logic [SW-1:0]     disp_sel,
  output logic [SW-1:0]     draw_sel,
  output logic              clear_busy,
  output logic              overrun
);

  clr_state_e     state_q, state_d;
  logic [SW-1:0]  disp_sel_q, disp_sel_d;
  logic [SW-1:0]  draw_sel_q, draw_sel_d;
  logic [SW-1:0]  clr_tgt_q, clr_tgt_d;
  logic [SW-1:0]  disp_rd_q, draw_rd_q;
  logic [TAW-1:0] clr_cnt_q, clr_cnt_d;
  logic           overrun_q, overrun_d;
  logic           busy;
  logic           swap_ok;

  assign busy       = (state_q == CLR_CLEAR);
  assign swap_ok    = swap && !busy;
  assign draw_ready = !(busy && (clr_tgt_q == draw_sel_q));

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    disp_sel_d = disp_sel_q;
    draw_sel_d = draw_sel_q;
    clr_tgt_d  = clr_tgt_q;
    clr_cnt_d  = clr_cnt_q;
    overrun_d  = swap && busy;
    if (swap_ok) begin
      disp_sel_d = draw_sel_q;
      draw_sel_d = (draw_sel_q == SW'(NUM_BUF-1)) ? '0 : draw_sel_q + 1'b1;
      clr_tgt_d  = disp_sel_q;
      clr_cnt_d  = '0;
      state_d    = CLR_CLEAR;
    end else if (busy) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == TAW'(TILES-1)) state_d = CLR_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLR_IDLE;
      disp_sel_q <= '0;
      draw_sel_q <= SW'(1);
      clr_tgt_q  <= '0;
      clr_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      disp_rd_q  <= '0;
      draw_rd_q  <= SW'(1);
    end else begin
      state_q    <= state_d;
      disp_sel_q <= disp_sel_d;
      draw_sel_q <= draw_sel_d;
      clr_tgt_q  <= clr_tgt_d;
      clr_cnt_q  <= clr_cnt_d;
      overrun_q  <= overrun_d;
      disp_rd_q  <= disp_sel_q;
      draw_rd_q  <= draw_sel_q;
    end
  end

  logic [PIX_W-1:0]  bank_q [NUM_BUF];
  logic [TILE_W-1:0] fill;

  assign fill = {TILE_PIX{clear_color}};

  // The clear target owns port A while busy; draw writes are gated by draw_ready.
  for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
    logic              is_draw;
    logic              is_clr;
    logic [TAW-1:0]    a_addr;
    logic [TILE_W-1:0] a_data;
    logic [TILE_PIX-1:0] a_mask;
    logic              a_we;
    logic [PAW-1:0]    b_addr;
    logic              b_we;

    assign is_draw = (draw_sel_q == SW'(b));
    assign is_clr  = busy && (clr_tgt_q == SW'(b));
    assign a_addr  = is_clr ? clr_cnt_q : draw_tile_addr;
    assign a_data  = is_clr ? fill      : draw_tile_data;
    assign a_mask  = is_clr ? '1        : draw_tile_mask;
    assign a_we    = is_clr || (is_draw && draw_tile_we && draw_ready);
    assign b_addr  = is_draw ? draw_pix_addr : disp_addr;
    assign b_we    = is_draw && draw_pix_we && draw_ready;

    linebuffer_bank #(
      .PIX_W  (PIX_W),
      .PIXELS (PIXELS)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .a_addr_i (a_addr),
      .a_data_i (a_data),
      .a_mask_i (a_mask),
      .a_we_i   (a_we),
      .b_addr_i (b_addr),
      .b_data_i (draw_pix_data),
      .b_we_i   (b_we),
      .b_q_o    (bank_q[b])
    );
  end

  assign disp_q     = bank_q[disp_rd_q];
  assign draw_pix_q = bank_q[draw_rd_q];
  assign disp_sel   = disp_sel_q;
  assign draw_sel   = draw_sel_q;
  assign clear_busy = busy;
  assign overrun    = overrun_q;

endmodule
